uart_tx_fifo: RTL and testbench

Byte buffer and launch controller that sits directly upstream of the UART top-level transmit path. It accepts bytes from a system-side producer at full clock rate and stores them in a circular FIFO. It drives the UART's `tx_en`/`data_in` pair one byte at a time, pacing launches from the UART's `tx_busy` status. This lets software or a DMA burst bytes without waiting for each serial frame.

---
 rtl/uart_tx_fifo.sv | 115 +++++++++++
 tb/tb_uart_tx_fifo.sv | 381 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// Circular byte FIFO feeding a UART transmitter.
// Paces one launch at a time from the UART busy level.
module uart_tx_fifo #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [7:0]        wr_data,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic              tx_en,
  output logic [7:0]        tx_data,
  input  logic              tx_busy
);

  localparam logic [ADDR_W:0] FULL_CNT =
    (ADDR_W+1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LAUNCH = 2'd1,
    S_WAIT   = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [7:0]        mem [DEPTH];
  logic [ADDR_W-1:0] wp;
  logic [ADDR_W-1:0] rp;
  logic              push;
  logic              pop;

  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);
  assign push  = wr_en && !full;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: begin
        if (!empty && !tx_busy) begin
          state_nxt = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        if (tx_busy) begin
          state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (!tx_busy) begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Request persists until the slower UART raises busy
  always_comb begin
    pop   = 1'b0;
    tx_en = 1'b0;
    unique case (state)
      S_IDLE:   pop   = !empty && !tx_busy;
      S_LAUNCH: tx_en = 1'b1;
      default:  ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push && !reset) begin
      mem[wp] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wp       <= '0;
      rp       <= '0;
      count    <= '0;
      overflow <= 1'b0;
      tx_data  <= 8'h00;
    end else begin
      if (push) begin
        wp <= wp + 1'b1;
      end
      if (wr_en && full) begin
        overflow <= 1'b1;
      end
      if (pop) begin
        tx_data <= mem[rp];
        rp      <= rp + 1'b1;
      end
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Randomized bench for uart_tx_fifo with a
// queue-based reference and a modelled UART.
module tb_uart_tx_fifo;

  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;

  logic              clk;
  logic              reset;
  logic              wr_en;
  logic [7:0]        wr_data;
  logic              full;
  logic              empty;
  logic [ADDR_W:0]   count;
  logic              overflow;
  logic              tx_en;
  logic [7:0]        tx_data;
  logic              tx_busy;

  int tests;
  int fails;

  uart_tx_fifo #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .full     (full),
    .empty    (empty),
    .count    (count),
    .overflow (overflow),
    .tx_en    (tx_en),
    .tx_data  (tx_data),
    .tx_busy  (tx_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // UART model: acks tx_en after a short delay, then stays busy
  int busy_cnt  = 0;
  int ack_cnt   = 0;
  int ack_delay = 0;
  int ack_max   = 0;
  int blen_min  = 3;
  int blen_max  = 3;
  bit force_busy = 1'b0;
  bit ack_hold   = 1'b0;

  assign tx_busy = force_busy || (busy_cnt != 0);

  always @(negedge clk) begin
    if (busy_cnt > 0) begin
      busy_cnt--;
    end else if (tx_en && !ack_hold && !force_busy) begin
      if (ack_cnt < ack_delay) begin
        ack_cnt++;
      end else begin
        busy_cnt  = $urandom_range(blen_max, blen_min);
        ack_cnt   = 0;
        ack_delay = $urandom_range(ack_max, 0);
      end
    end
  end

  // Reference: queue of accepted bytes, checked every edge
  logic [7:0] q[$];
  logic [7:0] launch_log[$];
  int         launches = 0;
  bit         exp_ovf  = 1'b0;
  bit         prev_en  = 1'b0;
  logic [7:0] prev_data = 8'h00;
  bit         p_wr;
  logic [7:0] p_data;
  bit         p_busy;
  bit         p_rst;
  int         p_size;
  logic [7:0] exp_b;

  always @(posedge clk) begin
    p_wr   = wr_en;
    p_data = wr_data;
    p_busy = tx_busy;
    p_rst  = reset;
    p_size = q.size();
    #1;
    if (p_rst) begin
      q.delete();
      exp_ovf = 1'b0;
      tests++;
      if (tx_en !== 1'b0 || count !== '0 ||
          empty !== 1'b1 || full !== 1'b0 ||
          overflow !== 1'b0 || tx_data !== 8'h00) begin
        fails++;
        $display("FAIL reset_state: en=%b cnt=%0d emp=%b ful=%b ovf=%b d=%h want 0 0 1 0 0 00",
                 tx_en, count, empty, full, overflow, tx_data);
      end
    end else begin
      if (tx_en && !prev_en) begin
        tests++;
        if (p_size == 0 || p_busy) begin
          fails++;
          $display("FAIL launch_cond: size=%0d busy=%b want size>0 busy=0",
                   p_size, p_busy);
        end else begin
          exp_b = q.pop_front();
          if (tx_data !== exp_b) begin
            fails++;
            $display("FAIL launch_order: got %h want %h", tx_data, exp_b);
          end
        end
        launch_log.push_back(tx_data);
        launches++;
      end else begin
        tests++;
        if (tx_data !== prev_data) begin
          fails++;
          $display("FAIL tx_data_hold: got %h want %h", tx_data, prev_data);
        end
      end
      if (p_wr) begin
        if (p_size < DEPTH) q.push_back(p_data);
        else exp_ovf = 1'b1;
      end
      if (prev_en && !tx_en && !p_busy) begin
        tests++;
        fails++;
        $display("FAIL en_drop: tx_en fell got busy=%b want 1", p_busy);
      end
      tests++;
      if (int'(count) != q.size() ||
          empty !== (q.size() == 0) ||
          full !== (q.size() == DEPTH) ||
          overflow !== exp_ovf) begin
        fails++;
        $display("FAIL occupancy: cnt=%0d emp=%b ful=%b ovf=%b want cnt=%0d ovf=%b",
                 count, empty, full, overflow, q.size(), exp_ovf);
      end
    end
    prev_en   = tx_en;
    prev_data = tx_data;
  end

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    wr_en = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while ((q.size() != 0 || tx_en || tx_busy) && n < 3000) begin
      @(posedge clk);
      n++;
    end
    #2;
    tests++;
    if (n >= 3000) begin
      fails++;
      $display("FAIL %s_timeout: left=%0d want 0", name, q.size());
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    tests++;
    if (tx_en !== 1'b0 || empty !== 1'b1 || count !== '0) begin
      fails++;
      $display("FAIL test_reset: en=%b emp=%b cnt=%0d want 0 1 0",
               tx_en, empty, count);
    end
    reset = 1'b0;
  endtask

  task automatic test_single();
    blen_min = 10;
    blen_max = 10;
    ack_max  = 0;
    @(negedge clk);
    wr_en   = 1'b1;
    wr_data = 8'hA5;
    @(posedge clk);
    @(negedge clk);
    wr_en = 1'b0;
    tests++;
    if (empty !== 1'b0 || tx_en !== 1'b0) begin
      fails++;
      $display("FAIL single_n: emp=%b en=%b want 0 0", empty, tx_en);
    end
    @(posedge clk);
    #1;
    tests++;
    if (tx_en !== 1'b1 || tx_data !== 8'hA5 || count !== '0) begin
      fails++;
      $display("FAIL single_n1: en=%b d=%h cnt=%0d want 1 a5 0",
               tx_en, tx_data, count);
    end
    wait_drain("single");
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp [3];
    int base;
    exp[0] = 8'h11;
    exp[1] = 8'h22;
    exp[2] = 8'h33;
    blen_min = 50;
    blen_max = 50;
    ack_max  = 2;
    base = launches;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      wr_en   = 1'b1;
      wr_data = exp[i];
    end
    @(negedge clk);
    wr_en = 1'b0;
    wait_drain("b2b");
    tests++;
    if (launches - base != 3) begin
      fails++;
      $display("FAIL b2b_count: got %0d want 3", launches - base);
    end else begin
      for (int i = 0; i < 3; i++) begin
        tests++;
        if (launch_log[base+i] !== exp[i]) begin
          fails++;
          $display("FAIL b2b_byte%0d: got %h want %h",
                   i, launch_log[base+i], exp[i]);
        end
      end
    end
  endtask

  task automatic test_overflow();
    force_busy = 1'b1;
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      wr_en   = 1'b1;
      wr_data = 8'($urandom);
      @(posedge clk);
      #2;
      if (i == 15) begin
        tests++;
        if (full !== 1'b1 || count !== 5'd16 || overflow !== 1'b0) begin
          fails++;
          $display("FAIL ovf_16: ful=%b cnt=%0d ovf=%b want 1 16 0",
                   full, count, overflow);
        end
      end
    end
    tests++;
    if (full !== 1'b1 || count !== 5'd16 || overflow !== 1'b1) begin
      fails++;
      $display("FAIL ovf_17: ful=%b cnt=%0d ovf=%b want 1 16 1",
               full, count, overflow);
    end
  endtask

  task automatic test_full_pop();
    blen_min = 2;
    blen_max = 5;
    @(negedge clk);
    force_busy = 1'b0;
    wr_en      = 1'b1;
    wr_data    = 8'hEE;
    @(posedge clk);
    #2;
    tests++;
    if (count !== 5'd15 || overflow !== 1'b1 || tx_en !== 1'b1) begin
      fails++;
      $display("FAIL full_pop: cnt=%0d ovf=%b en=%b want 15 1 1",
               count, overflow, tx_en);
    end
    @(negedge clk);
    wr_en = 1'b0;
    wait_drain("full_pop");
  endtask

  task automatic test_random();
    int base;
    int guard;
    do_reset();
    blen_min = 2;
    blen_max = 8;
    ack_max  = 2;
    base = launches;
    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(3, 0)) begin
        @(negedge clk);
        wr_en = 1'b0;
      end
      @(negedge clk);
      guard = 0;
      while (full && guard < 500) begin
        wr_en = 1'b0;
        @(negedge clk);
        guard++;
      end
      wr_en   = 1'b1;
      wr_data = 8'($urandom);
    end
    @(negedge clk);
    wr_en = 1'b0;
    wait_drain("random");
    tests++;
    if (launches - base != 40 || overflow !== 1'b0) begin
      fails++;
      $display("FAIL random_total: got %0d ovf=%b want 40 0",
               launches - base, overflow);
    end
  endtask

  task automatic test_reset_mid();
    int base;
    int n = 0;
    force_busy = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      wr_en   = 1'b1;
      wr_data = 8'($urandom);
    end
    @(negedge clk);
    wr_en      = 1'b0;
    ack_hold   = 1'b1;
    force_busy = 1'b0;
    while (!tx_en && n < 20) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (n >= 20) begin
      fails++;
      $display("FAIL mid_launch_timeout: en=%b want 1", tx_en);
    end
    reset = 1'b1;
    @(posedge clk);
    #2;
    tests++;
    if (tx_en !== 1'b0 || empty !== 1'b1 ||
        count !== '0 || overflow !== 1'b0) begin
      fails++;
      $display("FAIL reset_mid: en=%b emp=%b cnt=%0d ovf=%b want 0 1 0 0",
               tx_en, empty, count, overflow);
    end
    @(negedge clk);
    reset = 1'b0;
    base = launches;
    repeat (30) @(posedge clk);
    #2;
    tests++;
    if (launches != base || tx_en !== 1'b0) begin
      fails++;
      $display("FAIL reset_mid_quiet: launches=%0d en=%b want 0 0",
               launches - base, tx_en);
    end
    ack_hold = 1'b0;
  endtask

  initial begin
    tests   = 0;
    fails   = 0;
    reset   = 1'b1;
    wr_en   = 1'b0;
    wr_data = 8'h00;
    test_reset();
    test_single();
    test_back_to_back();
    test_overflow();
    test_full_pop();
    test_random();
    test_reset_mid();
    repeat (3) @(posedge clk);
    #2;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
